spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Parametrised SPI master, clocked by the system clock. It generates SCLK internally and supports all four
//  CPOL/CPHA modes, variable transfer lengths and multiple slave selects.
//  Sits between a command/register interface and the SPI pins, and shifts MSB-first.
//  Successor to the fixed-mode driver: adds mode select, SS decode, rx_valid handshake and length checking.
// PARAMETERS
//  CLK_DIVIDE  100  clk cycles per SCLK period; even, >=4; H = CLK_DIVIDE/2 (half-period)
//  SPI_MAXLEN  16   maximum bits per transfer
//  NUM_SS      4    number of slave-select outputs, >=2
// PORTS
//  clk          in   1                       system clock; all logic on posedge
//  sreset       in   1                       reset, synchronous to clk, active-high
//  start_cmd    in   1                       request transfer; accepted when start_cmd & spi_drv_rdy
//  spi_drv_rdy  out  1                       idle, can accept start_cmd
//  n_clks       in   $clog2(SPI_MAXLEN)+1    transfer length in bits, sampled at accept
//  tx_data      in   SPI_MAXLEN              bits [n-1:0] sent, bit n-1 first; sampled at accept
//  ss_sel       in   $clog2(NUM_SS)          slave index, sampled at accept
//  cpol, cpha   in   1 each                  SPI mode, sampled at accept
//  rx_data      out  SPI_MAXLEN              received word, right-aligned, upper bits zero
//  rx_valid     out  1                       1-cycle pulse: rx_data updated
//  SCLK         out  1                       SPI clock; idles at latched cpol
//  MOSI         out  1                       master out
//  MISO         in   1                       master in
//  SS_N         out  NUM_SS                  active-low selects; one-hot-low during transfer
// BEHAVIOUR
//  Reset values: spi_drv_rdy=1, rx_valid=0, rx_data=0, SCLK=0, MOSI=0, SS_N=all 1s, FSM=IDLE, cpol latch=0.
//  FSM: IDLE -> LEAD -> XFER -> TRAIL -> GAP -> IDLE. A half-period tick fires every H cycles while busy.
//  IDLE: rdy=1. On accept, latch cfg, assert SS_N[ss_sel] low next cycle, go to LEAD. rdy drops the cycle after accept.
//  Length rules: n_clks==0 -> start ignored (no SS, no rx_valid, rdy stays 1). n_clks>SPI_MAXLEN -> clamped to SPI_MAXLEN.
//  ss_sel>=NUM_SS: start ignored, same as n_clks==0.
//  LEAD: H cycles, SCLK=cpol. CPHA=0 drives bit n-1 on MOSI at LEAD entry.
//  XFER: 2n half-periods, SCLK toggles at each tick.
//   CPHA=0: sample MISO on leading edge, shift MOSI on trailing edge.
//   CPHA=1: shift MOSI on leading edge, sample on trailing edge.
//  TRAIL: H cycles, SCLK=cpol. At exit: SS_N all high, rx_data loaded, rx_valid=1 for one cycle.
//  GAP: H cycles with SS_N high (min deselect time). rdy=1 on return to IDLE.
//  SS_N low for exactly H*(2n+2) clk cycles; exactly n sample edges per transfer.
//  start_cmd while busy: ignored, no queueing. Config inputs may change freely while busy.
//  MOSI holds its last bit after the transfer.
//  sreset mid-transfer: next cycle all reset values; no rx_valid; partial data discarded.
// CONFIGURATION
//  `define SPI_LOOPBACK_EN: adds input port loopback_en (1b).
//   loopback_en=1: sampled bit is the internal MOSI value; the MISO pin is ignored.
//  Without the macro: port absent, MISO always sampled.
// STRUCTURE
//  spi_pkg: spi_state_t enum {IDLE,LEAD,XFER,TRAIL,GAP}; spi_mode_t struct {cpol,cpha}; clamp_len() function.
//  Sub-module spi_clk_gen: H-cycle counter, enable/clear, emits half_tick; restarts at 0 on enable.
// TESTING (CLK_DIVIDE=4, H=2, SPI_MAXLEN=16, NUM_SS=4)
//  Mode0, n=8, tx=0xA5, slave returns 0x3C -> MOSI 1,0,1,0,0,1,0,1; rx_data=0x003C; SS_N[0] low 36 cycles.
//  Mode3, n=16, tx=0xBEEF, ss_sel=2 -> only SS_N[2] low; SCLK idles 1; rx_data matches slave model.
//  n_clks=0, then ss_sel=5 -> no SS activity, rdy stays 1. n_clks=31 -> 16-bit transfer.
//  Start pulse during XFER -> ignored; exactly one rx_valid.
//  sreset at XFER bit 3 -> SS_N=4'hF and rdy=1 next cycle; no rx_valid.
//  Back-to-back start on rdy rise -> SS_N high >=2 cycles between transfers.
//  SPI_LOOPBACK_EN, loopback_en=1, MISO=0, tx=0x1234, n=16 -> rx_data=0x1234.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, latched mode and length clamping.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int unsigned clamp_len(input int unsigned n, input int unsigned maxlen);
    return (n > maxlen) ? maxlen : n;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: counts HALF clk cycles while enabled, restarting from 0 on enable or clear.
module spi_clk_gen #(
  parameter int unsigned HALF = 50
) (
  input  logic clk_i,
  input  logic sreset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic half_tick_o
);

  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i || (cnt_q == LAST)) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  assign half_tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (sreset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master, all CPOL/CPHA modes, MSB-first, variable length, decoded active-low selects.
// Define SPI_LOOPBACK_EN to add loopback_en, which feeds the internal MOSI back as the sampled bit.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIVIDE = 100,
  parameter int unsigned SPI_MAXLEN = 16,
  parameter int unsigned NUM_SS     = 4
) (
  input  logic                            clk,
  input  logic                            sreset,
  input  logic                            start_cmd,
  output logic                            spi_drv_rdy,
  input  logic [$clog2(SPI_MAXLEN):0]     n_clks,
  input  logic [SPI_MAXLEN-1:0]           tx_data,
  input  logic [$clog2(NUM_SS)-1:0]       ss_sel,
  input  logic                            cpol,
  input  logic                            cpha,
`ifdef SPI_LOOPBACK_EN
  input  logic                            loopback_en,
`endif
  output logic [SPI_MAXLEN-1:0]           rx_data,
  output logic                            rx_valid,
  output logic                            SCLK,
  output logic                            MOSI,
  input  logic                            MISO,
  output logic [NUM_SS-1:0]               SS_N
);

  localparam int unsigned LW   = $clog2(SPI_MAXLEN) + 1;
  localparam int unsigned SSW  = $clog2(NUM_SS);
  localparam int unsigned HALF = CLK_DIVIDE / 2;

  spi_state_t            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW:0]           hcnt_q, hcnt_d;
  logic [SPI_MAXLEN-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d, rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_SS-1:0]     ss_n_q, ss_n_d;

  logic                  half_tick, accept, ss_ok, miso_bit;
  logic                  edge_en, edge_lead, final_trail;
  logic [LW-1:0]         len_in;
  logic [LW:0]           last_hp, pre_last;
  logic [SPI_MAXLEN-1:0] aligned;

  spi_clk_gen #(.HALF(HALF)) u_clk_gen (
    .clk_i       (clk),
    .sreset_i    (sreset),
    .en_i        (state_q != IDLE),
    .clr_i       (accept),
    .half_tick_o (half_tick)
  );

`ifdef SPI_LOOPBACK_EN
  assign miso_bit = loopback_en ? mosi_q : MISO;
`else
  assign miso_bit = MISO;
`endif

  assign ss_ok   = ({1'b0, ss_sel} < (SSW + 1)'(NUM_SS));
  assign len_in  = LW'(clamp_len(32'(n_clks), SPI_MAXLEN));
  assign accept  = start_cmd && (state_q == IDLE) && (n_clks != '0) && ss_ok;
  // Left-align the word so the first bit to send always sits at the MSB of the shifter.
  assign aligned = tx_data << (SPI_MAXLEN - 32'(len_in));

  // XFER half-period h ends with edge h+1; edge 0 is issued when LEAD expires.
  assign last_hp     = {len_q, 1'b0} - 1'b1;
  assign pre_last    = last_hp - 1'b1;
  assign edge_en     = half_tick && ((state_q == LEAD) || ((state_q == XFER) && (hcnt_q != last_hp)));
  assign edge_lead   = (state_q == LEAD) || hcnt_q[0];
  assign final_trail = (state_q == XFER) && (hcnt_q == pre_last);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    hcnt_d     = hcnt_q;
    txsh_d     = txsh_q;
    rxsh_d     = rxsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d     = LEAD;
        mode_d.cpol = cpol;
        mode_d.cpha = cpha;
        len_d       = len_in;
        hcnt_d      = '0;
        rxsh_d      = '0;
        sclk_d      = cpol;
        ss_n_d      = ~(NUM_SS'(1) << ss_sel);
        if (!cpha) begin
          mosi_d = aligned[SPI_MAXLEN-1];
          txsh_d = aligned << 1;
        end else begin
          txsh_d = aligned;
        end
      end
      LEAD: if (half_tick) state_d = XFER;
      XFER: if (half_tick) begin
        if (hcnt_q == last_hp) state_d = TRAIL;
        else hcnt_d = hcnt_q + 1'b1;
      end
      TRAIL: if (half_tick) begin
        state_d    = GAP;
        ss_n_d     = '1;
        rx_data_d  = rxsh_q;
        rx_valid_d = 1'b1;
      end
      GAP: if (half_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (edge_en) begin
      sclk_d = ~sclk_q;
      if (edge_lead ^ mode_q.cpha) rxsh_d = {rxsh_q[SPI_MAXLEN-2:0], miso_bit};
      if (mode_q.cpha ? edge_lead : (!edge_lead && !final_trail)) begin
        mosi_d = txsh_q[SPI_MAXLEN-1];
        txsh_d = txsh_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      len_q      <= '0;
      hcnt_q     <= '0;
      txsh_q     <= '0;
      rxsh_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      hcnt_q     <= hcnt_d;
      txsh_q     <= txsh_d;
      rxsh_q     <= rxsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign spi_drv_rdy = (state_q == IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign SS_N        = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (CLK_DIVIDE=4) with a behavioural SPI slave on the pins.
module tb_spi_master_ctrl;

  localparam int NSS = 4;

  logic        clk = 1'b0;
  logic        sreset, start_cmd, cpol, cpha, MISO;
  logic [4:0]  n_clks;
  logic [15:0] tx_data;
  logic [1:0]  ss_sel;
  logic        spi_drv_rdy, rx_valid, SCLK, MOSI;
  logic [15:0] rx_data;
  logic [3:0]  SS_N;
`ifdef SPI_LOOPBACK_EN
  logic        loopback_en;
`endif

  logic        start5;
  logic [2:0]  ss_sel5;
  logic        rdy5, rx_valid5, sclk5, mosi5;
  logic [15:0] rx_data5;
  logic [4:0]  ss_n5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.CLK_DIVIDE(4), .SPI_MAXLEN(16), .NUM_SS(4)) u_dut (
    .clk(clk), .sreset(sreset), .start_cmd(start_cmd), .spi_drv_rdy(spi_drv_rdy),
    .n_clks(n_clks), .tx_data(tx_data), .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha),
`ifdef SPI_LOOPBACK_EN
    .loopback_en(loopback_en),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N)
  );

  // Five selects so an out-of-range index (5) is representable on the 3-bit ss_sel.
  spi_master_ctrl #(.CLK_DIVIDE(4), .SPI_MAXLEN(16), .NUM_SS(5)) u_ss5 (
    .clk(clk), .sreset(sreset), .start_cmd(start5), .spi_drv_rdy(rdy5),
    .n_clks(n_clks), .tx_data(tx_data), .ss_sel(ss_sel5), .cpol(cpol), .cpha(cpha),
`ifdef SPI_LOOPBACK_EN
    .loopback_en(loopback_en),
`endif
    .rx_data(rx_data5), .rx_valid(rx_valid5), .SCLK(sclk5), .MOSI(mosi5), .MISO(1'b0), .SS_N(ss_n5)
  );

  // Slave model and pin monitors, all evaluated on the falling clk edge.
  logic [15:0] sl_word;
  int          sl_n;
  logic        sl_cpol, sl_cpha;
  int          sl_bit = 0;
  int          samples = 0;
  logic [15:0] mosi_cap = '0;
  int          ss_low [NSS];
  int          rxv_cnt = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  logic        prev_all_hi = 1'b1;
  logic        sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    for (int i = 0; i < NSS; i++) if (!SS_N[i]) ss_low[i] <= ss_low[i] + 1;
    if (&SS_N) hi_run <= hi_run + 1;
    else if (prev_all_hi) begin
      last_gap  <= hi_run;
      hi_run    <= 0;
      sl_bit    <= sl_n - 1;
      samples   <= 0;
      mosi_cap  <= '0;
      sclk_prev <= SCLK;
      if (!sl_cpha) MISO <= sl_word[sl_n-1];
    end else if (SCLK !== sclk_prev) begin
      sclk_prev <= SCLK;
      if ((SCLK != sl_cpol) ^ sl_cpha) begin
        mosi_cap <= {mosi_cap[14:0], MOSI};
        samples  <= samples + 1;
      end else if (sl_cpha) begin
        if (sl_bit >= 0) MISO <= sl_word[sl_bit];
        sl_bit <= sl_bit - 1;
      end else begin
        if (sl_bit >= 1) MISO <= sl_word[sl_bit-1];
        sl_bit <= sl_bit - 1;
      end
    end
    prev_all_hi <= &SS_N;
  end

  task automatic run_xfer(input logic pol, input logic pha, input logic [4:0] n, input logic [15:0] tx,
                          input logic [1:0] ss, input logic [15:0] slw,
                          output logic [15:0] rx, output logic ok);
    @(negedge clk);
    sl_word = slw; sl_n = (n > 16) ? 16 : int'(n); sl_cpol = pol; sl_cpha = pha;
    cpol = pol; cpha = pha; n_clks = n; tx_data = tx; ss_sel = ss; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    ok = 1'b0;
    rx = '0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (rx_valid) begin ok = 1'b1; rx = rx_data; end
    end
    for (int i = 0; i < 20 && !spi_drv_rdy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    sreset = 1'b1; start_cmd = 1'b0; start5 = 1'b0; ss_sel5 = '0;
    cpol = 1'b0; cpha = 1'b0; n_clks = '0; tx_data = '0; ss_sel = '0;
    sl_word = '0; sl_n = 8; sl_cpol = 1'b0; sl_cpha = 1'b0;
`ifdef SPI_LOOPBACK_EN
    loopback_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    sreset = 1'b0;
    @(negedge clk);
    tests++; if (spi_drv_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got=%b exp=1", spi_drv_rdy); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    tests++; if (rx_data !== 16'h0000) begin fails++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    tests++; if (SCLK !== 1'b0) begin fails++; $display("FAIL reset_sclk got=%b exp=0", SCLK); end
    tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
    tests++; if (SS_N !== 4'hF) begin fails++; $display("FAIL reset_ss_n got=%h exp=f", SS_N); end
  endtask

  task automatic test_mode0();
    logic [15:0] rx; logic ok; int b [NSS];
    for (int i = 0; i < NSS; i++) b[i] = ss_low[i];
    run_xfer(1'b0, 1'b0, 5'd8, 16'h00A5, 2'd0, 16'h003C, rx, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL m0_done got=%b exp=1 (rx_valid timeout)", ok); end
    tests++; if (rx !== 16'h003C) begin fails++; $display("FAIL m0_rx got=%h exp=003c", rx); end
    tests++; if (mosi_cap !== 16'h00A5) begin fails++; $display("FAIL m0_mosi got=%h exp=00a5", mosi_cap); end
    tests++; if (samples !== 8) begin fails++; $display("FAIL m0_edges got=%0d exp=8", samples); end
    tests++; if (ss_low[0] - b[0] !== 36) begin fails++; $display("FAIL m0_ss0_low got=%0d exp=36", ss_low[0] - b[0]); end
    tests++; if ((ss_low[1] - b[1]) + (ss_low[2] - b[2]) + (ss_low[3] - b[3]) !== 0) begin
      fails++; $display("FAIL m0_other_ss got=%0d exp=0", (ss_low[1] - b[1]) + (ss_low[2] - b[2]) + (ss_low[3] - b[3]));
    end
  endtask

  task automatic test_mode3();
    logic [15:0] rx; logic ok; int b [NSS];
    for (int i = 0; i < NSS; i++) b[i] = ss_low[i];
    run_xfer(1'b1, 1'b1, 5'd16, 16'hBEEF, 2'd2, 16'h5AC3, rx, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL m3_done got=%b exp=1 (rx_valid timeout)", ok); end
    tests++; if (rx !== 16'h5AC3) begin fails++; $display("FAIL m3_rx got=%h exp=5ac3", rx); end
    tests++; if (mosi_cap !== 16'hBEEF) begin fails++; $display("FAIL m3_mosi got=%h exp=beef", mosi_cap); end
    tests++; if (samples !== 16) begin fails++; $display("FAIL m3_edges got=%0d exp=16", samples); end
    tests++; if (ss_low[2] - b[2] !== 68) begin fails++; $display("FAIL m3_ss2_low got=%0d exp=68", ss_low[2] - b[2]); end
    tests++; if ((ss_low[0] - b[0]) + (ss_low[1] - b[1]) + (ss_low[3] - b[3]) !== 0) begin
      fails++; $display("FAIL m3_other_ss got=%0d exp=0", (ss_low[0] - b[0]) + (ss_low[1] - b[1]) + (ss_low[3] - b[3]));
    end
    tests++; if (SCLK !== 1'b1) begin fails++; $display("FAIL m3_sclk_idle got=%b exp=1", SCLK); end
  endtask

  task automatic test_length_rules();
    logic [15:0] rx; logic ok; logic bad; int b1, rv;
    rv = rxv_cnt;
    bad = 1'b0;
    @(negedge clk);
    n_clks = 5'd0; ss_sel = 2'd0; start_cmd = 1'b1;
    repeat (10) begin @(negedge clk); if (spi_drv_rdy !== 1'b1 || SS_N !== 4'hF) bad = 1'b1; end
    start_cmd = 1'b0;
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL len0_ignored got=%b exp=0 (activity seen)", bad); end
    bad = 1'b0;
    n_clks = 5'd8; ss_sel5 = 3'd5; start5 = 1'b1;
    repeat (10) begin @(negedge clk); if (rdy5 !== 1'b1 || ss_n5 !== 5'h1F) bad = 1'b1; end
    start5 = 1'b0;
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL ss5_ignored got=%b exp=0 (activity seen)", bad); end
    tests++; if (rxv_cnt - rv !== 0) begin fails++; $display("FAIL ignored_rx_valid got=%0d exp=0", rxv_cnt - rv); end
    b1 = ss_low[1];
    run_xfer(1'b0, 1'b1, 5'd31, 16'h8001, 2'd1, 16'hC0DE, rx, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL clamp_done got=%b exp=1 (rx_valid timeout)", ok); end
    tests++; if (rx !== 16'hC0DE) begin fails++; $display("FAIL clamp_rx got=%h exp=c0de", rx); end
    tests++; if (samples !== 16) begin fails++; $display("FAIL clamp_edges got=%0d exp=16", samples); end
    tests++; if (mosi_cap !== 16'h8001) begin fails++; $display("FAIL clamp_mosi got=%h exp=8001", mosi_cap); end
    tests++; if (ss_low[1] - b1 !== 68) begin fails++; $display("FAIL clamp_ss1_low got=%0d exp=68", ss_low[1] - b1); end
  endtask

  task automatic test_busy_start();
    int rv, b0; logic done;
    rv = rxv_cnt; b0 = ss_low[0];
    @(negedge clk);
    sl_word = 16'h0096; sl_n = 8; sl_cpol = 1'b1; sl_cpha = 1'b0;
    cpol = 1'b1; cpha = 1'b0; n_clks = 5'd8; tx_data = 16'h005A; ss_sel = 2'd3; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    repeat (10) @(negedge clk);
    n_clks = 5'd4; ss_sel = 2'd0; tx_data = 16'hFFFF; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    for (int i = 0; i < 200 && !spi_drv_rdy; i++) @(negedge clk);
    done = spi_drv_rdy;
    repeat (20) @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL busy_done got=%b exp=1 (rdy timeout)", done); end
    tests++; if (rxv_cnt - rv !== 1) begin fails++; $display("FAIL busy_rx_valid_count got=%0d exp=1", rxv_cnt - rv); end
    tests++; if (rx_data !== 16'h0096) begin fails++; $display("FAIL busy_rx got=%h exp=0096", rx_data); end
    tests++; if (mosi_cap !== 16'h005A) begin fails++; $display("FAIL busy_mosi got=%h exp=005a", mosi_cap); end
    tests++; if (ss_low[0] - b0 !== 0) begin fails++; $display("FAIL busy_ss0_low got=%0d exp=0", ss_low[0] - b0); end
  endtask

  task automatic test_sreset_mid();
    int rv; logic got;
    rv = rxv_cnt;
    @(negedge clk);
    sl_word = 16'h00FF; sl_n = 8; sl_cpol = 1'b0; sl_cpha = 1'b0;
    cpol = 1'b0; cpha = 1'b0; n_clks = 5'd8; tx_data = 16'h00FF; ss_sel = 2'd1; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); if (samples == 3) got = 1'b1; end
    sreset = 1'b1;
    @(negedge clk);
    tests++; if (got !== 1'b1) begin fails++; $display("FAIL srst_reach_bit3 got=%b exp=1 (timeout)", got); end
    tests++; if (SS_N !== 4'hF) begin fails++; $display("FAIL srst_ss_n got=%h exp=f", SS_N); end
    tests++; if (spi_drv_rdy !== 1'b1) begin fails++; $display("FAIL srst_rdy got=%b exp=1", spi_drv_rdy); end
    tests++; if (SCLK !== 1'b0 || MOSI !== 1'b0) begin fails++; $display("FAIL srst_pins got=%b%b exp=00", SCLK, MOSI); end
    tests++; if (rx_data !== 16'h0000) begin fails++; $display("FAIL srst_rx_data got=%h exp=0000", rx_data); end
    sreset = 1'b0;
    repeat (60) @(negedge clk);
    tests++; if (rxv_cnt - rv !== 0) begin fails++; $display("FAIL srst_no_rx_valid got=%0d exp=0", rxv_cnt - rv); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx; logic ok, ok2; logic [15:0] rx2;
    run_xfer(1'b0, 1'b1, 5'd4, 16'h0009, 2'd0, 16'h0006, rx, ok);
    tests++; if (rx !== 16'h0006 || ok !== 1'b1) begin fails++; $display("FAIL b2b_first got=%h/%b exp=0006/1", rx, ok); end
    sl_word = 16'h00C5; sl_n = 8; sl_cpol = 1'b1; sl_cpha = 1'b1;
    cpol = 1'b1; cpha = 1'b1; n_clks = 5'd8; tx_data = 16'h0033; ss_sel = 2'd3; start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    ok2 = 1'b0; rx2 = '0;
    for (int i = 0; i < 2000 && !ok2; i++) begin @(negedge clk); if (rx_valid) begin ok2 = 1'b1; rx2 = rx_data; end end
    tests++; if (rx2 !== 16'h00C5 || ok2 !== 1'b1) begin fails++; $display("FAIL b2b_second got=%h/%b exp=00c5/1", rx2, ok2); end
    tests++; if (mosi_cap !== 16'h0033) begin fails++; $display("FAIL b2b_mosi got=%h exp=0033", mosi_cap); end
    tests++; if (last_gap < 2) begin fails++; $display("FAIL b2b_ss_gap got=%0d exp>=2", last_gap); end
    for (int i = 0; i < 20 && !spi_drv_rdy; i++) @(negedge clk);
  endtask

`ifdef SPI_LOOPBACK_EN
  task automatic test_loopback();
    logic [15:0] rx; logic ok;
    loopback_en = 1'b1;
    run_xfer(1'b0, 1'b0, 5'd16, 16'h1234, 2'd0, 16'h0000, rx, ok);
    loopback_en = 1'b0;
    tests++; if (rx !== 16'h1234 || ok !== 1'b1) begin fails++; $display("FAIL loopback_rx got=%h/%b exp=1234/1", rx, ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_length_rules();
    test_busy_start();
    test_sreset_mid();
    test_back_to_back();
`ifdef SPI_LOOPBACK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
